// File: rtl/read_sched_if.sv
// Bus bundle for the SRAM read scheduler: queue-manager inputs, SRAM read port and egress stream.
// The master modport is the scheduler side; slave is the queue manager / SRAM / egress side.
interface read_sched_if #(
  parameter int NUM_QUEUES = 8,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 64,
  parameter int WEIGHT_W   = 4
);
  logic                           sp0_wrr1;
  logic [NUM_QUEUES*WEIGHT_W-1:0] weights;
  logic                           ready;
  logic [NUM_QUEUES-1:0]          prepared;
  logic [NUM_QUEUES*ADDR_W-1:0]   head_addr;
  logic [NUM_QUEUES-1:0]          next_data;
  logic                           mem_req;
  logic [ADDR_W-1:0]              mem_addr;
  logic [DATA_W-1:0]              mem_data;
  logic                           mem_last;
  logic [ADDR_W-1:0]              mem_next_addr;
  logic [DATA_W-1:0]              rd_data;
  logic                           rd_sop;
  logic                           rd_vld;
  logic                           rd_eop;
  logic                           busy;
  logic                           len_err;

  modport master (
    input  sp0_wrr1, weights, ready, prepared, head_addr,
    input  mem_data, mem_last, mem_next_addr,
    output next_data, mem_req, mem_addr,
    output rd_data, rd_sop, rd_vld, rd_eop, busy, len_err
  );

  modport slave (
    output sp0_wrr1, weights, ready, prepared, head_addr,
    output mem_data, mem_last, mem_next_addr,
    input  next_data, mem_req, mem_addr,
    input  rd_data, rd_sop, rd_vld, rd_eop, busy, len_err
  );
endinterface

// File: rtl/read_sched_arbiter.sv
// SRAM read scheduler: grants a queue (strict priority or WRR), walks its packet's link list and
// streams it as sop/vld/eop words. Optional packet length limit under macro PKT_LEN_CHECK_EN.
module read_sched_arbiter #(
  parameter int NUM_QUEUES = 8,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 64,
  parameter int WEIGHT_W   = 4,
  parameter int MEM_LAT    = 1,
  parameter int MAX_WORDS  = 64
) (
  input  logic         clk,
  input  logic         rst,
  read_sched_if.master bus
);

  localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;

  state_t                state, state_d;
  logic [QW-1:0]         q_r, q_d;
  logic [QW-1:0]         ptr, ptr_d;
  logic [WEIGHT_W-1:0]   cred, cred_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic                  first_r, first_d;

  logic [NUM_QUEUES-1:0] next_data_r, next_data_d;
  logic                  mem_req_r, mem_req_d;
  logic [ADDR_W-1:0]     mem_addr_r, mem_addr_d;
  logic [DATA_W-1:0]     rd_data_r, rd_data_d;
  logic                  rd_sop_r, rd_sop_d;
  logic                  rd_vld_r, rd_vld_d;
  logic                  rd_eop_r, rd_eop_d;
  logic                  busy_r, busy_d;
  logic                  len_err_d;

`ifdef PKT_LEN_CHECK_EN
  localparam int WCW = $clog2(MAX_WORDS + 1);
  logic [WCW-1:0]        wc, wc_d;
  logic                  len_err_r;
`endif

  // Arbitration candidates
  logic [QW-1:0]         sp_q;
  logic [QW-1:0]         rr_q;
  logic                  rr_keep;
  logic [WEIGHT_W-1:0]   rr_w;
  logic                  end_pkt;
  logic                  trunc;

  always_comb begin
    sp_q = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (bus.prepared[i]) sp_q = QW'(i);
    end
    // Scan downward so the nearest prepared queue after ptr wins; ptr itself is the last resort.
    rr_q = ptr;
    for (int i = NUM_QUEUES; i >= 1; i--) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_QUEUES;
      if (bus.prepared[idx]) rr_q = QW'(idx);
    end
    rr_keep = bus.prepared[ptr] && (cred != '0);
    rr_w    = bus.weights[int'(rr_q)*WEIGHT_W +: WEIGHT_W];
  end

  always_comb begin
    state_d     = state;
    q_d         = q_r;
    ptr_d       = ptr;
    cred_d      = cred;
    cnt_d       = cnt;
    first_d     = first_r;
    mem_addr_d  = mem_addr_r;
    rd_data_d   = rd_data_r;
    busy_d      = busy_r;
    next_data_d = '0;
    mem_req_d   = 1'b0;
    rd_sop_d    = 1'b0;
    rd_vld_d    = 1'b0;
    rd_eop_d    = 1'b0;
    len_err_d   = 1'b0;
    end_pkt     = 1'b0;
    trunc       = 1'b0;
`ifdef PKT_LEN_CHECK_EN
    wc_d        = wc;
`endif
    case (state)
      IDLE: begin
        if (bus.ready && (|bus.prepared)) begin
          if (bus.sp0_wrr1) begin
            if (rr_keep) begin
              q_d    = ptr;
              cred_d = cred - WEIGHT_W'(1);
            end else begin
              q_d    = rr_q;
              ptr_d  = rr_q;
              cred_d = (rr_w == '0) ? '0 : rr_w - WEIGHT_W'(1);
            end
          end else begin
            q_d = sp_q;
          end
          mem_addr_d = bus.head_addr[int'(q_d)*ADDR_W +: ADDR_W];
          mem_req_d  = 1'b1;
          busy_d     = 1'b1;
          first_d    = 1'b1;
          state_d    = FETCH;
`ifdef PKT_LEN_CHECK_EN
          wc_d       = '0;
`endif
        end
      end
      FETCH: begin
        cnt_d   = CW'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          rd_data_d  = bus.mem_data;
          rd_vld_d   = 1'b1;
          rd_sop_d   = first_r;
          first_d    = 1'b0;
          mem_addr_d = bus.mem_next_addr;
`ifdef PKT_LEN_CHECK_EN
          wc_d       = wc + WCW'(1);
          trunc      = !bus.mem_last && (wc == WCW'(MAX_WORDS - 1));
`endif
          end_pkt    = bus.mem_last || trunc;
          len_err_d  = trunc;
          if (end_pkt) begin
            rd_eop_d    = 1'b1;
            next_data_d = NUM_QUEUES'(1) << q_r;
            busy_d      = 1'b0;
            state_d     = IDLE;
          end else begin
            mem_req_d = 1'b1;
            state_d   = FETCH;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      q_r         <= '0;
      ptr         <= '0;
      cred        <= '0;
      cnt         <= '0;
      first_r     <= 1'b0;
      next_data_r <= '0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= '0;
      rd_data_r   <= '0;
      rd_sop_r    <= 1'b0;
      rd_vld_r    <= 1'b0;
      rd_eop_r    <= 1'b0;
      busy_r      <= 1'b0;
`ifdef PKT_LEN_CHECK_EN
      wc          <= '0;
      len_err_r   <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      q_r         <= q_d;
      ptr         <= ptr_d;
      cred        <= cred_d;
      cnt         <= cnt_d;
      first_r     <= first_d;
      next_data_r <= next_data_d;
      mem_req_r   <= mem_req_d;
      mem_addr_r  <= mem_addr_d;
      rd_data_r   <= rd_data_d;
      rd_sop_r    <= rd_sop_d;
      rd_vld_r    <= rd_vld_d;
      rd_eop_r    <= rd_eop_d;
      busy_r      <= busy_d;
`ifdef PKT_LEN_CHECK_EN
      wc          <= wc_d;
      len_err_r   <= len_err_d;
`endif
    end
  end

  assign bus.next_data = next_data_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.rd_sop    = rd_sop_r;
  assign bus.rd_vld    = rd_vld_r;
  assign bus.rd_eop    = rd_eop_r;
  assign bus.busy      = busy_r;
`ifdef PKT_LEN_CHECK_EN
  assign bus.len_err   = len_err_r;
`else
  assign bus.len_err   = 1'b0;
  wire unused_len = len_err_d;
`endif

endmodule

// File: tb/tb_read_sched_arbiter.sv
// Bench for read_sched_arbiter: table of arbitration vectors, hand-written corner sequences and
// randomized packets checked against a queue/link-list reference model with an SRAM behavioural model.
module tb_read_sched_arbiter;
  localparam int NQ   = 8;
  localparam int AW   = 12;
  localparam int DW   = 64;
  localparam int WW   = 4;
  localparam int ML   = 1;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  read_sched_if #(.NUM_QUEUES(NQ), .ADDR_W(AW), .DATA_W(DW), .WEIGHT_W(WW)) bus ();

  read_sched_arbiter #(
    .NUM_QUEUES(NQ), .ADDR_W(AW), .DATA_W(DW), .WEIGHT_W(WW), .MEM_LAT(ML), .MAX_WORDS(MAXW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM contents and link lists
  logic [DW-1:0] mdata [0:4095];
  logic          mlast [0:4095];
  logic [AW-1:0] mnext [0:4095];
  logic [AW-1:0] apipe [0:ML-1];

  always @(posedge clk) begin
    apipe[0] <= bus.mem_addr;
    for (int k = 1; k < ML; k++) apipe[k] <= apipe[k-1];
  end
  assign bus.mem_data      = mdata[apipe[ML-1]];
  assign bus.mem_last      = mlast[apipe[ML-1]];
  assign bus.mem_next_addr = mnext[apipe[ML-1]];

  logic [AW-1:0] hd [NQ];
  logic [WW-1:0] wt [NQ];
  always_comb begin
    for (int i = 0; i < NQ; i++) begin
      bus.head_addr[i*AW +: AW] = hd[i];
      bus.weights[i*WW +: WW]   = wt[i];
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  int m_ptr    = 0;
  int m_cred   = 0;
  int chain_head [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic link(input int a, input int nx, input bit last);
    mdata[a] = {$urandom, $urandom};
    mnext[a] = AW'(nx);
    mlast[a] = last;
  endtask

  // Reference arbitration: spec-level priority / weighted round robin
  task automatic model_grant(input bit mode, input logic [NQ-1:0] prep, output int q);
    q = -1;
    if (!mode) begin
      for (int i = NQ - 1; i >= 0; i--) if (prep[i]) q = i;
    end else if (prep[m_ptr] && m_cred > 0) begin
      q = m_ptr;
      m_cred--;
    end else begin
      for (int i = 1; i <= NQ && q < 0; i++) begin
        if (prep[(m_ptr + i) % NQ]) begin
          q      = (m_ptr + i) % NQ;
          m_ptr  = q;
          m_cred = (wt[q] == 0) ? 0 : int'(wt[q]) - 1;
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_req"},   bus.mem_req,   0);
    chk({tag, " mem_addr"},  bus.mem_addr,  0);
    chk({tag, " rd_vld"},    bus.rd_vld,    0);
    chk({tag, " rd_sop"},    bus.rd_sop,    0);
    chk({tag, " rd_eop"},    bus.rd_eop,    0);
    chk({tag, " rd_data"},   bus.rd_data,   0);
    chk({tag, " next_data"}, bus.next_data, 0);
    chk({tag, " busy"},      bus.busy,      0);
    chk({tag, " len_err"},   bus.len_err,   0);
  endtask

  // One packet: issue ready, then check every mem_req and output word against the expected chain
  task automatic run_pkt(input bit mode, input logic [NQ-1:0] prep, input int exp_q,
                         input string tag, output int seen);
    int aq[$];
    int a, limit, w_req, w_vld, stray;
    bit stop, trunc, done;
    a = int'(hd[exp_q]);
    stop = 0;
    while (!stop) begin
      aq.push_back(a);
      if (mlast[a]) stop = 1;
`ifdef PKT_LEN_CHECK_EN
      if (aq.size() == MAXW) stop = 1;
`endif
      if (aq.size() >= 64) stop = 1;
      a = int'(mnext[a]);
    end
    trunc = !mlast[aq[aq.size()-1]];
    limit = aq.size() * (ML + 1) + ML + 4;
    w_req = 0; w_vld = 0; stray = 0; done = 0;
    bus.sp0_wrr1 = mode;
    bus.prepared = prep;
    bus.ready    = 1'b1;
    for (int k = 1; k <= limit && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.ready = 1'b0;
        chk({tag, " busy"}, bus.busy, 1);
      end
      if (bus.mem_req) begin
        if (w_req < aq.size()) begin
          chk({tag, " mem_addr"}, bus.mem_addr, aq[w_req]);
          chk({tag, " req cycle"}, k, 1 + w_req * (ML + 1));
        end else begin
          chk({tag, " extra mem_req"}, 1, 0);
        end
        w_req++;
      end
      if (bus.rd_vld) begin
        if (w_vld < aq.size()) begin
          chk({tag, " rd_data"},   bus.rd_data, mdata[aq[w_vld]]);
          chk({tag, " vld cycle"}, k, ML + 2 + w_vld * (ML + 1));
          chk({tag, " rd_sop"},    bus.rd_sop, w_vld == 0);
          chk({tag, " rd_eop"},    bus.rd_eop, w_vld == aq.size() - 1);
          chk({tag, " next_data"}, bus.next_data,
              (w_vld == aq.size() - 1) ? (64'(1) << exp_q) : 64'(0));
          chk({tag, " len_err"},   bus.len_err, (w_vld == aq.size() - 1) && trunc);
          if (w_vld == aq.size() - 1) done = 1;
        end
        w_vld++;
      end else if (bus.next_data != 0 || bus.len_err) begin
        stray++;
      end
    end
    chk({tag, " words"}, w_vld, aq.size());
    chk({tag, " stray pulses"}, stray, 0);
    @(negedge clk);
    chk({tag, " idle mem_req"}, bus.mem_req, 0);
    chk({tag, " idle busy"},    bus.busy, 0);
    chk({tag, " idle rd_vld"},  bus.rd_vld, 0);
    seen = w_vld;
  endtask

  typedef struct {
    bit            mode;
    logic [NQ-1:0] prep;
    int            exp_q;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int seen, q, cnt;
    tbl[0]  = '{0, 8'h24, 2};
    tbl[1]  = '{1, 8'h0A, 1};
    tbl[2]  = '{1, 8'h0A, 1};
    tbl[3]  = '{1, 8'h0A, 3};
    tbl[4]  = '{1, 8'h0A, 1};
    tbl[5]  = '{1, 8'h0A, 1};
    tbl[6]  = '{1, 8'h0A, 3};
    tbl[7]  = '{0, 8'h80, 7};
    tbl[8]  = '{0, 8'h0A, 1};
    tbl[9]  = '{1, 8'h0A, 1};
    tbl[10] = '{1, 8'h81, 7};
    tbl[11] = '{1, 8'h81, 0};
    tbl[12] = '{1, 8'h01, 0};

    for (int a = 0; a < 4096; a++) begin
      mdata[a] = {$urandom, $urandom};
      mlast[a] = 1'b1;
      mnext[a] = '0;
    end
    link(12'h010, 12'h011, 0); link(12'h011, 12'h0A0, 0); link(12'h0A0, 0, 1);
    for (int i = 0; i < NQ; i++) link(12'h020 + i, 0, 1);
    for (int i = 0; i < 6; i++) link(12'h100 + i, 12'h101 + i, i == 5);
    for (int i = 0; i < 4; i++) link(12'h200 + i, 12'h201 + i, i == 3);
    for (int j = 0; j < 8; j++) begin
      int len;
      len = $urandom_range(1, 6);
      chain_head[j] = 12'h400 + j * 16;
      for (int m = 0; m < len; m++)
        link(12'h400 + j * 16 + (m * 7) % 16, 12'h400 + j * 16 + ((m + 1) * 7) % 16, m == len - 1);
    end

    for (int i = 0; i < NQ; i++) begin
      hd[i] = AW'(12'h020 + i);
      wt[i] = '0;
    end
    wt[1] = 4'd2;
    wt[3] = 4'd1;
    bus.ready = 1'b0; bus.prepared = '0; bus.sp0_wrr1 = 1'b0;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 13; t++)
      run_pkt(tbl[t].mode, tbl[t].prep, tbl[t].exp_q, $sformatf("vec%0d", t), seen);

    hd[0] = 12'h010;
    run_pkt(0, 8'h01, 0, "chain3", seen);
    chk("chain3 count", seen, 3);

    hd[2] = 12'h022;
    run_pkt(0, 8'h04, 2, "single", seen);
    chk("single count", seen, 1);

    bus.prepared = '0;
    bus.ready    = 1'b1;
    @(negedge clk);
    bus.ready    = 1'b0;
    bus.prepared = 8'h01;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.mem_req || bus.busy) cnt++;
    end
    chk("dropped ready activity", cnt, 0);

    hd[0] = 12'h100;
    run_pkt(0, 8'h01, 0, "len", seen);
`ifdef PKT_LEN_CHECK_EN
    chk("len count", seen, MAXW);
`else
    chk("len count", seen, 6);
`endif

    hd[0] = 12'h200;
    bus.sp0_wrr1 = 1'b0;
    bus.prepared = 8'h01;
    bus.ready    = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid word1 vld", bus.rd_vld, 1);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("rstmid");
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.mem_req || bus.rd_vld || bus.next_data != 0) cnt++;
    end
    chk("rstmid after activity", cnt, 0);
    m_ptr = 0;
    m_cred = 0;
    hd[0] = 12'h010;
    run_pkt(0, 8'h01, 0, "after rst", seen);

    for (int r = 0; r < 40; r++) begin
      bit mode;
      logic [NQ-1:0] prep;
      mode = 1'($urandom_range(0, 1));
      prep = NQ'($urandom_range(1, 255));
      for (int i = 0; i < NQ; i++) begin
        wt[i] = WW'($urandom_range(0, 15));
        hd[i] = AW'(chain_head[$urandom_range(0, 7)]);
      end
      model_grant(mode, prep, q);
      run_pkt(mode, prep, q, $sformatf("rnd%0d", r), seen);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
